// File: rtl/stream_out_buffer.sv
// rtl/stream_out_buffer.sv - parameterised register FIFO with push, pop, head and count
module stream_out_buffer #(
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = 8,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  do_push;
    logic                  do_pop;

    // DEPTH need not be a power of two, so wrap by compare rather than overflow
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop of the head frees a slot, so a push into a full buffer is allowed alongside it
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (srst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= wrap_inc(tail);
            end
            if (do_pop) begin
                head <= wrap_inc(head);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - credit-based read adapter from sync_fifo to a valid/ready stream
module fifo_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    localparam int BUF_DEPTH   = READ_LATENCY + 2,
    localparam int CNT_W       = $clog2(READ_LATENCY + 3)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      buf_count
);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "fifo_stream_reader: DATA_WIDTH must be >= 1");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "fifo_stream_reader: READ_LATENCY must be in 1..4");
    end

    logic [READ_LATENCY-1:0] pend;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W:0]          credit_sum;
    logic                    capture;
    logic                    pop;

    // Count reads issued whose data has not yet reached the buffer
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pend[i]);
        end
    end

    // Issue only when every outstanding word is guaranteed a buffer slot; m_ready is not involved
    always_comb begin
        credit_sum = {1'b0, inflight} + {1'b0, buf_count};
        fifo_rd_en = !srst && !fifo_empty && (credit_sum < (CNT_W + 1)'(BUF_DEPTH));
    end

    // Shift the read strobe down the latency pipe; the MSB lines up with valid fifo_dout
    always_ff @(posedge clk) begin
        if (srst) begin
            pend <= '0;
        end else begin
            pend <= READ_LATENCY'({pend, fifo_rd_en});
        end
    end

    assign capture = pend[READ_LATENCY-1];
    assign m_valid = (buf_count != '0);
    assign pop     = m_valid && m_ready;

    stream_out_buffer #(
        .DEPTH      (BUF_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .srst      (srst),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (m_data),
        .count     (buf_count)
    );

`ifdef DEBUG
    logic                  hold_q;
    logic [DATA_WIDTH-1:0] hold_data_q;

    // Remember a stalled beat so the next cycle can confirm the data did not move
    always_ff @(posedge clk) begin
        if (srst) begin
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            hold_q      <= m_valid && !m_ready;
            hold_data_q <= m_data;
        end
    end

    // Protocol checks on the FIFO side and the stream side
    always_ff @(posedge clk) begin
        if (!srst) begin
            assert (!(fifo_rd_en && fifo_empty))
                else $error("fifo_stream_reader: read issued while FIFO empty");
            assert (!(capture && (buf_count == CNT_W'(BUF_DEPTH))))
                else $error("fifo_stream_reader: capture into full buffer");
            assert (!hold_q || (m_data == hold_data_q))
                else $error("fifo_stream_reader: m_data changed while stalled");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed bench over READ_LATENCY 1..4 with a sync_fifo model
module tb_fifo_stream_reader;

    localparam int NL = 4;

    logic       clk = 1'b0;
    logic       srst;
    logic       m_ready;
    logic       empty_force;
    logic       rd_en_a [NL];
    logic [7:0] dout_a  [NL];
    logic       empty_a [NL];
    logic [7:0] data_a  [NL];
    logic       valid_a [NL];
    logic [2:0] bc_a    [NL];

    logic [7:0] stim [$];
    int rd_ptr [NL];
    int out_ptr [NL];
    int rd_cnt [NL];
    int first_rd [NL];
    int first_val [NL];
    int val_cnt [NL];
    int pop_cnt [NL];
    int last_pop [NL];
    int max_gap [NL];
    int cyc = 0;
    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int L  = g + 1;
        localparam int CW = $clog2(L + 3);

        logic [CW-1:0] bc;
        logic [7:0]    pipe_d [L];
        logic          pipe_v [L];
        logic          rd_s;
        logic          srst_s;
        logic          hold_s;
        logic [7:0]    hold_d;

        fifo_stream_reader #(
            .DATA_WIDTH   (8),
            .READ_LATENCY (L)
        ) dut (
            .clk        (clk),
            .srst       (srst),
            .fifo_empty (empty_a[g]),
            .fifo_dout  (dout_a[g]),
            .fifo_rd_en (rd_en_a[g]),
            .m_data     (data_a[g]),
            .m_valid    (valid_a[g]),
            .m_ready    (m_ready),
            .buf_count  (bc)
        );

        assign bc_a[g] = 3'(bc);

        initial begin
            rd_s       = 1'b0;
            srst_s     = 1'b0;
            hold_s     = 1'b0;
            hold_d     = '0;
            empty_a[g] = 1'b1;
            dout_a[g]  = '0;
            for (int i = 0; i < L; i++) begin
                pipe_v[i] = 1'b0;
                pipe_d[i] = '0;
            end
        end

        // Sample the DUT mid-cycle: protocol, scoreboard and timing statistics
        always @(negedge clk) begin
            srst_s = srst;
            rd_s   = rd_en_a[g];
            if (!srst) begin
                if (rd_en_a[g]) begin
                    check_eq($sformatf("rd_en_while_empty L%0d", L), 32'(empty_a[g]), 0);
                    rd_cnt[g]++;
                    if (first_rd[g] < 0) first_rd[g] = cyc;
                end
                if (hold_s) check_eq($sformatf("m_data_hold L%0d", L), 32'(data_a[g]), 32'(hold_d));
                if (valid_a[g]) begin
                    val_cnt[g]++;
                    if (first_val[g] < 0) first_val[g] = cyc;
                end
                if (valid_a[g] && m_ready) begin
                    if (out_ptr[g] < stim.size())
                        check_eq($sformatf("m_data L%0d #%0d", L, out_ptr[g]), 32'(data_a[g]), 32'(stim[out_ptr[g]]));
                    else
                        check_eq($sformatf("extra_word L%0d", L), out_ptr[g] + 1, stim.size());
                    out_ptr[g]++;
                    pop_cnt[g]++;
                    if (last_pop[g] >= 0 && cyc - last_pop[g] > max_gap[g]) max_gap[g] = cyc - last_pop[g];
                    last_pop[g] = cyc;
                end
                hold_s = valid_a[g] && !m_ready;
                hold_d = data_a[g];
            end else begin
                hold_s = 1'b0;
            end
        end

        // sync_fifo model: registered read with L stages, shared reset, empty from occupancy
        always @(posedge clk) begin
            #1;
            if (srst_s) begin
                for (int i = 0; i < L; i++) pipe_v[i] = 1'b0;
                rd_ptr[g]  = stim.size();
                out_ptr[g] = stim.size();
            end else begin
                for (int i = L - 1; i > 0; i--) begin
                    pipe_v[i] = pipe_v[i-1];
                    pipe_d[i] = pipe_d[i-1];
                end
                pipe_v[0] = rd_s;
                pipe_d[0] = 8'hEE;
                if (rd_s) begin
                    if (rd_ptr[g] < stim.size()) pipe_d[0] = stim[rd_ptr[g]];
                    rd_ptr[g]++;
                end
            end
            dout_a[g] = pipe_v[L-1] ? pipe_d[L-1] : 8'hEE;
            #2;
            empty_a[g] = (rd_ptr[g] >= stim.size()) || empty_force;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NL; i++) begin
            rd_cnt[i]    = 0;
            first_rd[i]  = -1;
            first_val[i] = -1;
            val_cnt[i]   = 0;
            pop_cnt[i]   = 0;
            last_pop[i]  = -1;
            max_gap[i]   = 0;
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NL; i++) begin
            if (out_ptr[i] < stim.size()) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_delivered(input string tag, input int words);
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("%s pop_cnt L%0d", tag, i + 1), pop_cnt[i], words);
            check_eq($sformatf("%s out_ptr L%0d", tag, i + 1), out_ptr[i], stim.size());
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        srst        = 1'b1;
        m_ready     = 1'b0;
        empty_force = 1'b0;
        for (int i = 0; i < NL; i++) begin
            rd_ptr[i]  = 0;
            out_ptr[i] = 0;
        end
        clear_stats();

        repeat (3) tick();
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("reset rd_en L%0d", i + 1), 32'(rd_en_a[i]), 0);
            check_eq($sformatf("reset m_valid L%0d", i + 1), 32'(valid_a[i]), 0);
            check_eq($sformatf("reset m_data L%0d", i + 1), 32'(data_a[i]), 0);
            check_eq($sformatf("reset buf_count L%0d", i + 1), 32'(bc_a[i]), 0);
        end
        tick();
        srst = 1'b0;

        // Four words, always ready: latency L+1 and back-to-back output
        m_ready = 1'b1;
        clear_stats();
        for (int k = 0; k < 4; k++) stim.push_back(8'hA1 + 8'(k));
        repeat (12) tick();
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("t1 latency L%0d", i + 1), first_val[i] - first_rd[i], i + 2);
            check_eq($sformatf("t1 max_gap L%0d", i + 1), max_gap[i], 1);
        end
        check_delivered("t1", 4);

        // Back-pressure: reads stop at BUF_DEPTH, buffer fills, then drains without bubbles
        m_ready = 1'b0;
        clear_stats();
        for (int k = 0; k < 10; k++) stim.push_back(8'h10 + 8'(k));
        repeat (15) tick();
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("t2 rd pulses L%0d", i + 1), rd_cnt[i], i + 3);
            check_eq($sformatf("t2 buf_count L%0d", i + 1), 32'(bc_a[i]), i + 3);
        end
        m_ready = 1'b1;
        repeat (25) tick();
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("t2 max_gap L%0d", i + 1), max_gap[i], 1);
        end
        check_delivered("t2", 10);

        // Random ready at 50%, 1000 words
        clear_stats();
        for (int k = 0; k < 1000; k++) stim.push_back(8'($urandom));
        for (int k = 0; k < 8000 && !all_done(); k++) begin
            m_ready = 1'($urandom % 2);
            tick();
        end
        m_ready = 1'b1;
        check_delivered("t3", 1000);

        // FIFO empty toggling every 3 cycles
        clear_stats();
        for (int k = 0; k < 30; k++) stim.push_back(8'h40 + 8'(k));
        for (int k = 0; k < 400 && !all_done(); k++) begin
            if (k % 3 == 0) empty_force = ~empty_force;
            tick();
        end
        empty_force = 1'b0;
        tick();
        check_delivered("t4", 30);

        // Reset with words in flight and buffered (L=3: 3 in flight, 2 buffered)
        m_ready = 1'b0;
        clear_stats();
        tick();
        for (int k = 0; k < 20; k++) stim.push_back(8'h80 + 8'(k));
        repeat (5) tick();
        srst = 1'b1;
        @(negedge clk);
        check_eq("t5 pre-reset buf_count L3", 32'(bc_a[2]), 2);
        tick();
        srst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("t5 post-reset m_valid L%0d", i + 1), 32'(valid_a[i]), 0);
            check_eq($sformatf("t5 post-reset buf_count L%0d", i + 1), 32'(bc_a[i]), 0);
        end
        tick();
        m_ready = 1'b1;
        clear_stats();
        stim.push_back(8'h5A);
        repeat (10) tick();
        check_delivered("t5", 1);

        // Single word: valid rises L+1 cycles after the read and lasts one cycle
        clear_stats();
        stim.push_back(8'hC3);
        repeat (12) tick();
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("t6 latency L%0d", i + 1), first_val[i] - first_rd[i], i + 2);
            check_eq($sformatf("t6 valid cycles L%0d", i + 1), val_cnt[i], 1);
        end
        check_delivered("t6", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
